// File: rtl/lifo_pkg.sv
// Shared widths and drain state encoding for the LIFO read-side client.
package lifo_pkg;

    localparam int LIFO_WIDTH = 16;
    localparam int LIFO_DEPTH = 16;
    localparam int LIFO_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } drain_state_t;

endpackage

// File: rtl/lifo_out_buf.sv
// Two-entry {data, last} FIFO that absorbs popped words while the consumer stalls.
module lifo_out_buf
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             last0_q, last0_d, last1_q, last1_d;
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count_q;
    assign out_data  = rd_ptr_q ? data1_q : data0_q;
    // Stale last bit of a drained entry must not leak out while idle.
    assign out_last  = out_valid && (rd_ptr_q ? last1_q : last0_q);

    always_comb begin
        data0_d  = data0_q;
        data1_d  = data1_q;
        last0_d  = last0_q;
        last1_d  = last1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            if (wr_ptr_q) begin
                data1_d = in_data;
                last1_d = in_last;
            end else begin
                data0_d = in_data;
                last0_d = in_last;
            end
            wr_ptr_d = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_q  <= '0;
            data1_q  <= '0;
            last0_q  <= 1'b0;
            last1_q  <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            last0_q  <= last0_d;
            last1_q  <= last1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lifo_drain_reader.sv
// Pops N words from the LIFO and streams them out top-first with a last flag.
//   state | meaning
//   IDLE  | ready for a drain command
//   DRAIN | issuing pops, capturing registered pop data
//   FLUSH | no more pops; waiting for the buffer to empty
//   DONE  | one-cycle completion pulse with count and short flag
module lifo_drain_reader
    import lifo_pkg::*;
#(
    parameter int WIDTH   = LIFO_WIDTH,
    parameter int MAX_CNT = LIFO_DEPTH,
    parameter int CNT_W   = LIFO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             lifo_pop,
    input  logic             lifo_empty,
    input  logic [WIDTH-1:0] lifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             done,
    output logic [CNT_W-1:0] done_count,
    output logic             done_short
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    drain_state_t     state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] delivered_q, delivered_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;
    logic             short_q, short_d;
    logic             inflight_q, inflight_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             done_q, done_d;
    logic             done_short_q, done_short_d;

    logic [1:0]       buf_occ, occ_after;
    logic             buf_in_ready, buf_wr, buf_wr_last, deq, pop;
    logic [CNT_W-1:0] req_count;

    assign req_count = (cmd_count > MAX_N) ? MAX_N : cmd_count;
    assign deq       = m_valid && m_ready;
    assign occ_after = buf_occ - {1'b0, deq};
    // Reserve a buffer slot for every pop so a stalled consumer never loses data.
    assign pop = (state_q == DRAIN) && (remaining_q != '0) && !lifo_empty
               && ((occ_after + {1'b0, inflight_q}) < 2'd2);
    assign buf_wr = inflight_q && buf_in_ready;
    // lifo_empty already shows the post-pop pointer when the data is captured.
    assign buf_wr_last = (remaining_q == '0) || lifo_empty;

    lifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (buf_wr),
        .in_ready  (buf_in_ready),
        .in_data   (lifo_data),
        .in_last   (buf_wr_last),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .occupancy (buf_occ)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        delivered_d  = delivered_q + {{(CNT_W-1){1'b0}}, deq};
        short_d      = short_q;
        inflight_d   = pop;
        cmd_ready_d  = cmd_ready_q;
        done_d       = 1'b0;
        done_count_d = done_count_q;
        done_short_d = done_short_q;
        if (pop) begin
            remaining_d = remaining_q - ONE;
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    remaining_d = req_count;
                    delivered_d = '0;
                    short_d     = 1'b0;
                    cmd_ready_d = 1'b0;
                    if (req_count == '0) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        done_count_d = '0;
                        done_short_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((remaining_q != '0) && lifo_empty && !inflight_q) begin
                    short_d = 1'b1;
                    state_d = FLUSH;
                end else if ((remaining_q == '0) && !inflight_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((buf_occ == 2'd0) && !inflight_q) begin
                    state_d      = DONE;
                    done_d       = 1'b1;
                    done_count_d = delivered_q;
                    done_short_d = short_q;
                end
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            delivered_q  <= '0;
            short_q      <= 1'b0;
            inflight_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            done_count_q <= '0;
            done_short_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            delivered_q  <= delivered_d;
            short_q      <= short_d;
            inflight_q   <= inflight_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            done_count_q <= done_count_d;
            done_short_q <= done_short_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign lifo_pop   = pop;
    assign done       = done_q;
    assign done_count = done_count_q;
    assign done_short = done_short_q;

endmodule

// File: tb/tb_lifo_drain_reader.sv
// Scoreboard bench: a behavioural LIFO feeds the reader; expected words come from stack snapshots.
module tb_lifo_drain_reader;

    localparam int WIDTH   = 16;
    localparam int MAX_CNT = 16;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             lifo_pop;
    logic             lifo_empty = 1'b1;
    logic [WIDTH-1:0] lifo_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             done;
    logic [CNT_W-1:0] done_count;
    logic             done_short;

    logic             wr_push = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] mem [MAX_CNT];
    int               sp = 0;

    int tests = 0, fails = 0, cyc = 0, acc_cnt = 0, outstanding = 0;
    int ready_mode = 0, pat = 0;

    typedef struct packed {logic [WIDTH-1:0] data; logic last;} word_t;
    typedef struct packed {logic [CNT_W-1:0] count; logic short_f;} done_t;
    word_t exp_q[$];
    done_t exp_done[$];
    int    hs_cyc[$];

    lifo_drain_reader #(.WIDTH(WIDTH), .MAX_CNT(MAX_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_count(cmd_count), .lifo_pop(lifo_pop), .lifo_empty(lifo_empty),
        .lifo_data(lifo_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .done(done), .done_count(done_count),
        .done_short(done_short)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stack with registered data_out/empty; push+pop swaps the top.
    always @(posedge clk) begin
        if (lifo_pop && sp > 0) begin
            lifo_data <= mem[sp-1];
            if (wr_push) mem[sp-1] = wr_data;
            else sp = sp - 1;
        end else if (wr_push && sp < MAX_CNT) begin
            mem[sp] = wr_data;
            sp = sp + 1;
        end
        lifo_empty <= (sp == 0);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (pat == 0) || (pat == 3);
                pat = (pat + 1) % 4;
            end
            default: m_ready = (($urandom & 3) != 0);
        endcase
    end

    always @(negedge clk) begin : monitor
        word_t w;
        done_t d;
        int    hs;
        if (!rst) begin
            exp_q.delete();
            exp_done.delete();
            outstanding = 0;
        end else begin
            hs = (m_valid && m_ready) ? 1 : 0;
            if (lifo_pop) begin
                tests++;
                if (lifo_empty) begin
                    fails++;
                    $display("FAIL pop_while_empty: lifo_empty=%0b required 0 (cycle %0d)", lifo_empty, cyc);
                end
                tests++;
                if (outstanding + 1 - hs > 2) begin
                    fails++;
                    $display("FAIL pop_outstanding: %0d words held/in flight, required <= 2 (cycle %0d)", outstanding + 1 - hs, cyc);
                end
            end
            if (hs != 0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got data=0x%0h last=%0b, required no word", m_data, m_last);
                end else begin
                    w = exp_q.pop_front();
                    if (m_data !== w.data || m_last !== w.last) begin
                        fails++;
                        $display("FAIL word: got data=0x%0h last=%0b, required data=0x%0h last=%0b",
                                 m_data, m_last, w.data, w.last);
                    end
                end
                acc_cnt++;
                hs_cyc.push_back(cyc);
            end
            if (done) begin
                tests++;
                if (exp_done.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got count=%0d short=%0b, required no done", done_count, done_short);
                end else begin
                    d = exp_done.pop_front();
                    if (done_count !== d.count || done_short !== d.short_f) begin
                        fails++;
                        $display("FAIL done: got count=%0d short=%0b, required count=%0d short=%0b",
                                 done_count, done_short, d.count, d.short_f);
                    end
                end
            end
            outstanding = outstanding + (lifo_pop ? 1 : 0) - hs;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        wr_data = d;
        wr_push = 1'b1;
        @(posedge clk);
        #1;
        wr_push = 1'b0;
    endtask

    // Expected stream: the top min(N, depth) words, last on the final one.
    task automatic issue_cmd(input int n, input bit auto_exp);
        int k, nc;
        bit ok;
        nc = (n > MAX_CNT) ? MAX_CNT : n;
        if (auto_exp) begin
            k = (nc < sp) ? nc : sp;
            for (int i = 0; i < k; i++) exp_q.push_back(word_t'{mem[sp-1-i], (i == k-1)});
            exp_done.push_back(done_t'{CNT_W'(k), (sp < nc)});
        end
        cmd_count = CNT_W'(n);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        #1;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({cmd_ready, lifo_pop, m_valid, m_last, done, done_short, m_data, done_count});
    endfunction

    initial begin
        int base, k, n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 32'({1'b1, 26'd0}));
        rst = 1'b1;
        @(posedge clk);
        #1;

        push_word(16'h00A1); push_word(16'h00A2); push_word(16'h00A3);
        issue_cmd(3, 1'b1);
        @(negedge clk);
        check("t1_pop_latency", 32'(lifo_pop), 32'd1);
        wait_done("t1");
        check("t1_consecutive", 32'(hs_cyc[$] - hs_cyc[$-2]), 32'd2);

        push_word(16'h1111); push_word(16'h2222);
        issue_cmd(5, 1'b1);
        wait_done("t2");

        issue_cmd(4, 1'b1);
        wait_done("t3_empty");
        issue_cmd(0, 1'b1);
        @(negedge clk);
        check("t3_zero_done_latency", 32'(done), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) push_word(16'(i));
        ready_mode = 1;
        pat = 0;
        issue_cmd(16, 1'b1);
        wait_done("t4");
        ready_mode = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        base = acc_cnt;
        issue_cmd(8, 1'b1);
        for (int t = 0; t < 200 && acc_cnt < base + 3; t++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_reset_outputs", out_vec(), 32'({1'b1, 26'd0}));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        issue_cmd(1, 1'b1);
        wait_done("t5_one");
        issue_cmd(16, 1'b1);
        wait_done("t5_rest");

        for (int i = 0; i < 6; i++) push_word(16'(i));
        exp_q.push_back(word_t'{16'h0005, 1'b0});
        exp_q.push_back(word_t'{16'hBEEF, 1'b1});
        exp_done.push_back(done_t'{CNT_W'(2), 1'b0});
        issue_cmd(2, 1'b0);
        wr_data = 16'hBEEF;
        wr_push = 1'b1;
        @(negedge clk);
        check("t6_pop_with_push", 32'(lifo_pop), 32'd1);
        @(posedge clk); #1;
        wr_push = 1'b0;
        wait_done("t6");
        issue_cmd(16, 1'b1);
        wait_done("t6_rest");

        for (int it = 0; it < 12; it++) begin
            ready_mode = $urandom_range(0, 2);
            k = $urandom_range(0, MAX_CNT - sp);
            for (int i = 0; i < k; i++) push_word(16'($urandom));
            n = $urandom_range(0, 20);
            issue_cmd(n, 1'b1);
            wait_done("rand");
            @(posedge clk); #1;
        end

        check("final_done_left", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
